// File: rtl/cv32e40p_obi_resp_pkg.sv
// Shared types and elaboration helpers for the OBI memory responder.
package cv32e40p_obi_resp_pkg;

    // One response-pipeline slot: rdata is kept 0 whenever valid is 0.
    typedef struct packed {
        logic        valid;
        logic [31:0] rdata;
    } obi_resp_t;

    localparam int MAX_LATENCY = 8;

    // Legal parameter combinations for the responder.
    function automatic bit obi_resp_params_ok(int depth, int latency, int max_outstanding);
        return (depth >= 1) && ((depth & (depth - 1)) == 0) &&
               (latency >= 1) && (latency <= MAX_LATENCY) &&
               (max_outstanding >= 1) && (max_outstanding <= latency + 1);
    endfunction

endpackage

// File: rtl/cv32e40p_obi_resp_pipe.sv
// Fixed-latency response delay line; stage 0 loads on the accept edge.
module cv32e40p_obi_resp_pipe
    import cv32e40p_obi_resp_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  obi_resp_t resp_in,
    output obi_resp_t resp_out
);

    obi_resp_t stage_q [LATENCY];

    // Shift responses forward one stage per cycle; reset drops everything in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < LATENCY; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= resp_in;
            for (int i = 1; i < LATENCY; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign resp_out = stage_q[LATENCY-1];

endmodule

// File: rtl/cv32e40p_obi_mem_responder.sv
// OBI memory-side responder: word RAM, grant/stall control, in-order fixed-latency responses.
module cv32e40p_obi_mem_responder
    import cv32e40p_obi_resp_pkg::*;
#(
    parameter int DEPTH           = 1024,
    parameter int LATENCY         = 1,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic [3:0]  outstanding_o
);

    localparam int IDX_W = $clog2(DEPTH);

    if (!obi_resp_params_ok(DEPTH, LATENCY, MAX_OUTSTANDING)) begin : g_param_check
        $error("cv32e40p_obi_mem_responder: illegal DEPTH/LATENCY/MAX_OUTSTANDING combination");
    end

    logic [31:0]      mem_q [DEPTH];
    logic [IDX_W-1:0] idx;
    logic             accept;
    logic [3:0]       outstanding_q;
    obi_resp_t        resp_in;
    obi_resp_t        resp_out;
    logic             unused_addr;

    // Upper address bits alias onto the low index; byte offset is ignored.
    assign idx         = addr_i[IDX_W+1:2];
    assign unused_addr = ^{addr_i[31:IDX_W+2], addr_i[1:0]};

    // Grant looks at the count before this edge's update, so a response leaving
    // in the same cycle does not free a slot until the next cycle.
    assign gnt_o  = req_i & ~stall_i & ~rst_i & (outstanding_q < 4'(MAX_OUTSTANDING));
    assign accept = req_i & gnt_o;

    // Build the response entering the delay line; reads sample RAM before any same-edge write.
    always_comb begin
        resp_in       = '0;
        resp_in.valid = accept;
        if (accept && !we_i) begin
            resp_in.rdata = mem_q[idx];
        end
    end

    // Byte-masked RAM write at the accept edge; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (accept && we_i) begin
            for (int k = 0; k < 4; k++) begin
                if (be_i[k]) begin
                    mem_q[idx][8*k +: 8] <= wdata_i[8*k +: 8];
                end
            end
        end
    end

    // Outstanding counter: +1 per accept, -1 per response, unchanged when both coincide.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            outstanding_q <= '0;
        end else begin
            if (accept && !resp_out.valid) begin
                outstanding_q <= outstanding_q + 4'd1;
            end else if (!accept && resp_out.valid) begin
                assert (outstanding_q != 4'd0);
                outstanding_q <= outstanding_q - 4'd1;
            end
            assert (outstanding_q <= 4'(MAX_OUTSTANDING));
        end
    end

    cv32e40p_obi_resp_pipe #(
        .LATENCY (LATENCY)
    ) u_resp_pipe (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .resp_in  (resp_in),
        .resp_out (resp_out)
    );

    assign rvalid_o      = resp_out.valid;
    assign rdata_o       = resp_out.rdata;
    assign outstanding_o = outstanding_q;

endmodule

// File: tb/tb_cv32e40p_obi_mem_responder.sv
// Bench for the OBI memory responder: two configurations driven side by side
// and compared every cycle against a transaction-level reference model.
module tb_cv32e40p_obi_mem_responder;

    localparam int DEPTH = 1024;
    localparam int LAT0  = 1;
    localparam int MO0   = 2;
    localparam int LAT1  = 3;
    localparam int MO1   = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       stall, req, we, gnt, rvalid;
    logic [1:0][3:0]  be, outst;
    logic [1:0][31:0] addr, wdata, rdata;

    always #5 clk = ~clk;

    cv32e40p_obi_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT0), .MAX_OUTSTANDING(MO0)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .stall_i(stall[0]), .req_i(req[0]), .gnt_o(gnt[0]),
        .addr_i(addr[0]), .we_i(we[0]), .be_i(be[0]), .wdata_i(wdata[0]),
        .rvalid_o(rvalid[0]), .rdata_o(rdata[0]), .outstanding_o(outst[0])
    );

    cv32e40p_obi_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT1), .MAX_OUTSTANDING(MO1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .stall_i(stall[1]), .req_i(req[1]), .gnt_o(gnt[1]),
        .addr_i(addr[1]), .we_i(we[1]), .be_i(be[1]), .wdata_i(wdata[1]),
        .rvalid_o(rvalid[1]), .rdata_o(rdata[1]), .outstanding_o(outst[1])
    );

    // Reference model: word memory keyed by (instance, word index) and a list of
    // pending responses, each due at a fixed cycle number.
    typedef struct {
        int          inst;
        int          due;
        logic [31:0] data;
        bit          known;
    } exp_t;

    exp_t        exp_q [$];
    logic [31:0] mem_m [int];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit full_chk = 0;

    logic [1:0]       exp_gnt, exp_rv, last_acc, seen_rv;
    logic [1:0][31:0] seen_rdata;
    int               head [2];

    function automatic int lat_of(int i);
        return (i == 0) ? LAT0 : LAT1;
    endfunction

    function automatic int mo_of(int i);
        return (i == 0) ? MO0 : MO1;
    endfunction

    task automatic check_val(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %08h, expected %08h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock cycle: compare outputs mid-cycle, then advance the model at the edge.
    task automatic step();
        exp_t nq [$];
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            int n = 0;
            int h = -1;
            for (int k = 0; k < exp_q.size(); k++) begin
                if (exp_q[k].inst == i) begin
                    if (h < 0) h = k;
                    n++;
                end
            end
            head[i]       = h;
            exp_gnt[i]    = req[i] & ~stall[i] & ~rst & (n < mo_of(i));
            exp_rv[i]     = (h >= 0) && (exp_q[h].due == cyc);
            seen_rv[i]    = rvalid[i];
            seen_rdata[i] = rdata[i];
            check_val($sformatf("gnt%0d", i), 32'(gnt[i]), 32'(exp_gnt[i]));
            if (full_chk) begin
                check_val($sformatf("rvalid%0d", i), 32'(rvalid[i]), 32'(exp_rv[i]));
                check_val($sformatf("outstanding%0d", i), 32'(outst[i]), 32'(n));
                if (!exp_rv[i])
                    check_val($sformatf("rdata_idle%0d", i), rdata[i], 32'h0);
                else if (exp_q[h].known)
                    check_val($sformatf("rdata%0d", i), rdata[i], exp_q[h].data);
            end
        end
        @(posedge clk);
        last_acc = '0;
        if (rst) begin
            exp_q.delete();
        end else begin
            for (int k = 0; k < exp_q.size(); k++) begin
                if (!((exp_rv[0] && k == head[0]) || (exp_rv[1] && k == head[1])))
                    nq.push_back(exp_q[k]);
            end
            exp_q = nq;
            for (int i = 0; i < 2; i++) begin
                if (req[i] && exp_gnt[i]) begin
                    exp_t e;
                    int key;
                    key     = i * DEPTH + int'((addr[i] >> 2) % DEPTH);
                    e.inst  = i;
                    e.due   = cyc + lat_of(i);
                    e.data  = 32'h0;
                    e.known = 1'b1;
                    if (we[i]) begin
                        if (mem_m.exists(key) || be[i] == 4'hF) begin
                            logic [31:0] w;
                            w = mem_m.exists(key) ? mem_m[key] : 32'h0;
                            for (int b = 0; b < 4; b++)
                                if (be[i][b]) w[8*b +: 8] = wdata[i][8*b +: 8];
                            mem_m[key] = w;
                        end
                    end else if (mem_m.exists(key)) begin
                        e.data = mem_m[key];
                    end else begin
                        e.known = 1'b0;
                    end
                    exp_q.push_back(e);
                    last_acc[i] = 1'b1;
                end
            end
        end
        #1;
        cyc++;
    endtask

    task automatic idle(int n);
        for (int t = 0; t < n; t++) step();
    endtask

    // Present one transaction, holding it until granted (bounded wait).
    task automatic issue(int i, bit w, logic [31:0] a, logic [31:0] d, logic [3:0] b);
        req[i] = 1'b1; we[i] = w; addr[i] = a; wdata[i] = d; be[i] = b;
        for (int t = 0; t < 30; t++) begin
            step();
            if (last_acc[i]) begin
                req[i] = 1'b0;
                return;
            end
        end
        check_val($sformatf("issue_timeout%0d", i), 32'h0, 32'h1);
        req[i] = 1'b0;
    endtask

    initial begin
        int rv_count;
        bit held [2];
        rst = 1'b1; stall = '0; req = 2'b11; we = '0; be = '0; addr = '0; wdata = '0;

        // Reset with requests asserted: no grant while in reset.
        step();
        full_chk = 1;
        step();
        step();
        rst = 1'b0; req = '0;
        idle(2);

        // Write then read-after-write on the single-cycle-latency instance.
        issue(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        issue(0, 1'b0, 32'h10, 32'h0, 4'h0);
        step();
        check_val("raw_rvalid", 32'(seen_rv[0]), 32'h1);
        check_val("raw_rdata", seen_rdata[0], 32'hDEADBEEF);

        // Partial byte-enable write merges with the existing word.
        issue(0, 1'b1, 32'h20, 32'h11223344, 4'hF);
        issue(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101);
        issue(0, 1'b0, 32'h20, 32'h0, 4'h0);
        step();
        check_val("be_merge", seen_rdata[0], 32'h11BB33DD);
        issue(0, 1'b1, 32'h24, 32'hCAFEF00D, 4'h0);
        issue(0, 1'b0, 32'h24, 32'h0, 4'h0);
        idle(2);

        // Back-to-back reads on the latency-3 instance: grant drops at the limit.
        for (int k = 0; k < 4; k++)
            issue(1, 1'b1, 32'h100 + 32'(4*k), 32'hA5000000 + 32'(k), 4'hF);
        idle(4);
        for (int k = 0; k < 4; k++)
            issue(1, 1'b0, 32'h100 + 32'(4*k), 32'h0, 4'h0);
        idle(5);

        // Stall with request held, then release.
        stall[0] = 1'b1; req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h10;
        idle(5);
        stall[0] = 1'b0;
        step();
        check_val("stall_release_accept", 32'(last_acc[0]), 32'h1);
        req[0] = 1'b0;
        idle(3);

        // Reset with two reads in flight: responses dropped, RAM retained.
        issue(1, 1'b0, 32'h100, 32'h0, 4'h0);
        issue(1, 1'b0, 32'h104, 32'h0, 4'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        rv_count = 0;
        for (int t = 0; t < 6; t++) begin
            step();
            if (seen_rv[1]) rv_count++;
        end
        check_val("no_rvalid_after_reset", 32'(rv_count), 32'h0);
        issue(1, 1'b0, 32'h108, 32'h0, 4'h0);
        idle(4);
        check_val("ram_kept_over_reset", 32'(exp_q.size()), 32'h0);

        // Preload the random address pool in both instances.
        for (int i = 0; i < 2; i++)
            for (int s = 0; s < 16; s++)
                issue(i, 1'b1, 32'((64 + s) * 4), $urandom, 4'hF);
        idle(4);

        // Randomized traffic with stalls, aliasing addresses and occasional resets.
        held[0] = 0; held[1] = 0;
        for (int t = 0; t < 3000; t++) begin
            rst = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < 2; i++) begin
                stall[i] = ($urandom_range(0, 4) == 0);
                if (!held[i]) begin
                    req[i]   = ($urandom_range(0, 9) < 7);
                    we[i]    = $urandom_range(0, 1);
                    be[i]    = 4'($urandom_range(0, 15));
                    wdata[i] = $urandom;
                    addr[i]  = 32'((64 + $urandom_range(0, 15) + DEPTH * $urandom_range(0, 3)) * 4
                                   + $urandom_range(0, 3));
                end
            end
            step();
            for (int i = 0; i < 2; i++)
                held[i] = req[i] && !last_acc[i] && !rst;
        end
        rst = 1'b0; req = '0; stall = '0;
        idle(6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
